// File: rtl/imem_fetch_unit_pkg.sv
// ============================================================================
// Module  : imem_fetch_unit_pkg
// Brief   : Shared sizing constants for the instruction memory and fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_unit_pkg;

    localparam int ISIZE           = 16;
    localparam int DSIZE           = 32;
    localparam int MAX_LINE_LENGTH = 256;

    // Memory and fetch unit both size themselves from these two values.
    localparam int IMEM_DEPTH      = 32 * ISIZE;
    localparam int RESET_PC        = 0;

endpackage : imem_fetch_unit_pkg

`default_nettype wire

// File: rtl/imem_fetch_unit_queue.sv
// ============================================================================
// Module  : fetch_queue
// Brief   : Synchronous FIFO holding {pc, instr} entries between fetch and decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule : fetch_queue

`default_nettype wire

// File: rtl/imem_fetch_unit.sv
// ============================================================================
// Module  : imem_fetch_unit
// Brief   : PC owner and requester for the instruction memory; queues fetched
//           words and hands them to decode with valid/ready and redirect flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_unit
    import imem_fetch_unit_pkg::*;
#(
    parameter int AW        = ISIZE,
    parameter int DW        = DSIZE,
    parameter int MEM_DEPTH = IMEM_DEPTH,
    parameter int QDEPTH    = 2,
    parameter int RESET_PC  = imem_fetch_unit_pkg::RESET_PC
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fetch_en_i,
    output logic [AW-1:0] imem_addr_o,
    output logic          imem_wen_o,
    output logic [DW-1:0] imem_wdata_o,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          if_valid_o,
    output logic [DW-1:0] if_instr_o,
    output logic [AW-1:0] if_pc_o,
    input  logic          id_ready_i,
    input  logic          redir_valid_i,
    input  logic [AW-1:0] redir_pc_i,
    output logic          fetch_err_o,
    output logic [31:0]   fetch_count_o
);

    localparam logic [AW-1:0] LAST_PC = AW'(MEM_DEPTH - 1);

    logic [AW-1:0]            pc_q, pc_d;
    logic                     err_q, err_d;
    logic [31:0]              cnt_q, cnt_d;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_q_full;
    logic                     w_q_empty;
    logic [$clog2(QDEPTH):0]  w_q_count;
    logic [AW+DW-1:0]         w_q_head;
    logic                     w_unused;

    assign w_pop  = if_valid_o & id_ready_i & ~redir_valid_i;
    assign w_push = fetch_en_i & ~err_q & ~redir_valid_i & (~w_q_full | w_pop);

    fetch_queue #(
        .WIDTH (AW + DW),
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redir_valid_i),
        .wdata_i ({pc_q, imem_rdata_i}),
        .rdata_o (w_q_head),
        .full_o  (w_q_full),
        .empty_o (w_q_empty),
        .count_o (w_q_count)
    );

    assign w_unused = ^w_q_count;

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        cnt_d = cnt_q;
        // A redirect overrides everything, including a head offered this cycle.
        if (redir_valid_i) begin
            pc_d  = redir_pc_i;
            err_d = (redir_pc_i > LAST_PC);
        end else if (w_push) begin
            pc_d  = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
        end
        if (w_pop) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= AW'(RESET_PC);
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign imem_wen_o    = 1'b0;
    assign imem_wdata_o  = '0;
    assign if_valid_o    = ~w_q_empty;
    assign if_pc_o       = w_q_head[AW+DW-1:DW];
    assign if_instr_o    = w_q_head[DW-1:0];
    assign fetch_err_o   = err_q;
    assign fetch_count_o = cnt_q;

endmodule : imem_fetch_unit

`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
// ============================================================================
// Module  : tb_imem_fetch_unit
// Brief   : Directed self-checking bench for imem_fetch_unit with a preloaded
//           combinational-read memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_unit;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst_n;
    logic          fetch_en;
    logic [AW-1:0] imem_addr;
    logic          imem_wen;
    logic [DW-1:0] imem_wdata;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          id_ready;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic          fetch_err;
    logic [31:0]   fetch_count;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    imem_fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_en_i    (fetch_en),
        .imem_addr_o   (imem_addr),
        .imem_wen_o    (imem_wen),
        .imem_wdata_o  (imem_wdata),
        .imem_rdata_i  (imem_rdata),
        .if_valid_o    (if_valid),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc),
        .id_ready_i    (id_ready),
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .fetch_err_o   (fetch_err),
        .fetch_count_o (fetch_count)
    );

    assign imem_rdata = (imem_addr < AW'(DEPTH)) ? mem[imem_addr[8:0]] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redir_valid = 1'b0; redir_pc = '0;
        tick(); tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b0, 16'd0, 32'd0})
            $display("FAIL reset_head: got v=%b pc=%0d instr=%h want v=0 pc=0 instr=0", if_valid, if_pc, if_instr);
        else n_pass++;
        n_checks++;
        if ({fetch_err, fetch_count, imem_addr, imem_wen, imem_wdata} !== {1'b0, 32'd0, 16'd0, 1'b0, 32'd0})
            $display("FAIL reset_state: got err=%b cnt=%0d addr=%0d wen=%b wdata=%h want 0", fetch_err, fetch_count, imem_addr, imem_wen, imem_wdata);
        else n_pass++;
        rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h0; exp_instr[1] = 32'h05031000;
        exp_instr[2] = 32'h0; exp_instr[3] = 32'h00430800;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 16'(k), exp_instr[k], 32'(k)})
                $display("FAIL stream_%0d: got v=%b pc=%0d instr=%h cnt=%0d want v=1 pc=%0d instr=%h cnt=%0d",
                         k, if_valid, if_pc, if_instr, fetch_count, k, exp_instr[k], k);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (fetch_count !== 32'd4)
            $display("FAIL stream_count: got %0d want 4", fetch_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        // Head is pc 4 with pc register at 5 on entry.
        id_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_pc, if_instr, imem_addr, fetch_count} !== {1'b1, 16'd4, 32'd0, 16'd6, 32'd4})
                $display("FAIL stall_%0d: got v=%b pc=%0d instr=%h addr=%0d cnt=%0d want v=1 pc=4 instr=0 addr=6 cnt=4",
                         k, if_valid, if_pc, if_instr, imem_addr, fetch_count);
            else n_pass++;
        end
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({if_valid, if_pc, fetch_count} !== {1'b1, 16'(5 + k), 32'(5 + k)})
                $display("FAIL resume_%0d: got v=%b pc=%0d cnt=%0d want v=1 pc=%0d cnt=%0d",
                         k, if_valid, if_pc, fetch_count, 5 + k, 5 + k);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        // Queue is full (pc 7, 8) with pc register at 9.
        redir_valid = 1'b1; redir_pc = 16'd9;
        tick();
        redir_valid = 1'b0;
        n_checks++;
        if ({if_valid, fetch_count} !== {1'b0, 32'd7})
            $display("FAIL redir_cancel: got v=%b cnt=%0d want v=0 cnt=7", if_valid, fetch_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 16'd9, 32'h03fa5000, 32'd7})
            $display("FAIL redir_target: got v=%b pc=%0d instr=%h cnt=%0d want v=1 pc=9 instr=03fa5000 cnt=7",
                     if_valid, if_pc, if_instr, fetch_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 16'd10, 32'h18E40001, 32'd8})
            $display("FAIL redir_next: got v=%b pc=%0d instr=%h cnt=%0d want v=1 pc=10 instr=18e40001 cnt=8",
                     if_valid, if_pc, if_instr, fetch_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1; redir_pc = 16'(DEPTH - 1);
        tick();
        redir_valid = 1'b0;
        tick();
        n_checks++;
        if ({if_valid, if_pc, fetch_count} !== {1'b1, 16'(DEPTH - 1), 32'd8})
            $display("FAIL wrap_last: got v=%b pc=%0d cnt=%0d want v=1 pc=%0d cnt=8", if_valid, if_pc, fetch_count, DEPTH - 1);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, if_pc, fetch_count} !== {1'b1, 16'd0, 32'd9})
            $display("FAIL wrap_zero: got v=%b pc=%0d cnt=%0d want v=1 pc=0 cnt=9", if_valid, if_pc, fetch_count);
        else n_pass++;
    endtask

    task automatic test_range_error();
        int bad;
        redir_valid = 1'b1; redir_pc = 16'(DEPTH + 4);
        tick();
        redir_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (if_valid !== 1'b0 || fetch_err !== 1'b1 || imem_addr !== 16'(DEPTH + 4)) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL range_err: got %0d bad cycles (last v=%b err=%b addr=%0d) want 0 bad cycles",
                     bad, if_valid, fetch_err, imem_addr);
        else n_pass++;
        redir_valid = 1'b1; redir_pc = 16'd3;
        tick();
        redir_valid = 1'b0;
        n_checks++;
        if ({fetch_err, if_valid} !== 2'b00)
            $display("FAIL range_clear: got err=%b v=%b want err=0 v=0", fetch_err, if_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 16'd3, 32'h00430800})
            $display("FAIL range_resume: got v=%b pc=%0d instr=%h want v=1 pc=3 instr=00430800", if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_valid, imem_addr, fetch_err, fetch_count} !== {1'b0, 16'd0, 1'b0, 32'd0})
            $display("FAIL async_reset: got v=%b addr=%0d err=%b cnt=%0d want v=0 addr=0 err=0 cnt=0",
                     if_valid, imem_addr, fetch_err, fetch_count);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 16'd0, 32'd0, 32'd0})
            $display("FAIL restart_0: got v=%b pc=%0d instr=%h cnt=%0d want v=1 pc=0 instr=0 cnt=0",
                     if_valid, if_pc, if_instr, fetch_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 16'd1, 32'h05031000, 32'd1})
            $display("FAIL restart_1: got v=%b pc=%0d instr=%h cnt=%0d want v=1 pc=1 instr=05031000 cnt=1",
                     if_valid, if_pc, if_instr, fetch_count);
        else n_pass++;
    endtask

    task automatic test_fetch_disable();
        // Head is pc 1, pc register at 2; the queue drains without refilling.
        fetch_en = 1'b0;
        tick();
        n_checks++;
        if ({if_valid, imem_addr, fetch_count} !== {1'b0, 16'd2, 32'd2})
            $display("FAIL disable_drain: got v=%b addr=%0d cnt=%0d want v=0 addr=2 cnt=2", if_valid, imem_addr, fetch_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({if_valid, imem_addr} !== {1'b0, 16'd2})
            $display("FAIL disable_hold: got v=%b addr=%0d want v=0 addr=2", if_valid, imem_addr);
        else n_pass++;
        fetch_en = 1'b1;
        tick();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 16'd2})
            $display("FAIL disable_resume: got v=%b pc=%0d want v=1 pc=2", if_valid, if_pc);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[1]  = 32'h05031000;
        mem[3]  = 32'h00430800;
        mem[9]  = 32'h03fa5000;
        mem[10] = 32'h18E40001;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_range_error();
        test_async_reset();
        test_fetch_disable();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_fetch_unit

`default_nettype wire
